// File: rtl/arbitro_rr_n.sv
// arbitro_rr_n: round-robin distributor from one source FIFO to N_CH destination FIFOs; ARB_STALL_CNT_EN adds stall_cnt
module arbitro_rr_n #(
  parameter int N_CH = 4,
  parameter int PTR_W = 2,
  parameter bit SKIP_FULL = 1,
  parameter logic [3:0] INIT_CODE = 4'b0001
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic [3:0]       state,
  input  logic             empty,
  input  logic [N_CH-1:0]  almost_full,
  output logic             pop,
  output logic [N_CH-1:0]  push,
  output logic [PTR_W-1:0] grant_idx
`ifdef ARB_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);
  logic [PTR_W-1:0] rr_ptr, cand, nxt;
  logic [PTR_W:0] sum;
  logic found, in_init;
  assign in_init = state == INIT_CODE;
  // Scan from rr_ptr downward in priority so the nearest free channel wins; without skipping only offset 0 is eligible
  always_comb begin
    cand = rr_ptr;
    found = 1'b0;
    sum = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_CH)) sum = sum - (PTR_W+1)'(N_CH);
      if ((SKIP_FULL || k == 0) && !almost_full[sum[PTR_W-1:0]]) begin
        cand = sum[PTR_W-1:0];
        found = 1'b1;
      end
    end
  end
  assign pop = !in_init && !empty && found;
  assign grant_idx = pop ? cand : rr_ptr;
  assign nxt = (grant_idx == PTR_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
  // Pointer advances past each grant, and the push lands one cycle after the pop to match source read latency
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr <= '0;
      push <= '0;
    end else begin
      rr_ptr <= pop ? nxt : in_init ? '0 : rr_ptr;
      push <= pop ? {{(N_CH-1){1'b0}}, 1'b1} << grant_idx : '0;
    end
  end
`ifdef ARB_STALL_CNT_EN
  // Count cycles where data waits but no destination can take it; saturating, cleared in INIT
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) stall_cnt <= '0;
    else stall_cnt <= in_init ? '0 : (!empty && !pop && stall_cnt != 16'hFFFF) ? stall_cnt + 16'd1 : stall_cnt;
  end
`endif
endmodule

// File: doc/arbitro_rr_n.md
ARBITRO_RR_N -- requirements
Module: arbitro_rr_n

Interface
REQ-001 Parameter N_CH, default 4: number of output FIFOs served; legal range 2..16.
REQ-002 Parameter PTR_W, default 2: pointer width, SHALL equal ceil(log2(N_CH)).
REQ-003 Parameter SKIP_FULL, default 1: 1 = skip almost-full channels; 0 = wait on the current channel.
REQ-004 Parameter INIT_CODE, default 4'b0001: value of state that means INIT.
REQ-005 clk  input  1  single clock; all flops rising-edge.
REQ-006 reset_L  input  1  asynchronous, active-low reset.
REQ-007 state  input  4  system FSM state; equal to INIT_CODE means INIT.
REQ-008 empty  input  1  source FIFO empty.
REQ-009 almost_full  input  N_CH  per-destination almost-full, bit i = channel i.
REQ-010 pop  output  1  source FIFO read strobe, combinational.
REQ-011 push  output  N_CH  destination write strobes, registered, one-hot or zero.
REQ-012 grant_idx  output  PTR_W  channel selected this cycle; valid when pop=1.
REQ-013 stall_cnt  output  16  stall counter; present only when ARB_STALL_CNT_EN is defined.

Function
REQ-014 Block SHALL hold a registered round-robin pointer rr_ptr (PTR_W bits) in range 0..N_CH-1.
REQ-015 Candidate channel: SKIP_FULL=1 -> first index c at or after rr_ptr, modulo N_CH, with almost_full[c]=0; SKIP_FULL=0 -> c=rr_ptr only if almost_full[rr_ptr]=0.
REQ-016 pop SHALL be 1 iff state!=INIT_CODE, empty=0, and a candidate exists; otherwise 0.
REQ-017 grant_idx SHALL equal the candidate when pop=1 and SHALL hold rr_ptr when pop=0.
REQ-018 On a cycle with pop=1, the next rr_ptr SHALL be (grant_idx+1) mod N_CH, wrapping N_CH-1 -> 0 including non-power-of-2 N_CH.
REQ-019 On a cycle with pop=0, rr_ptr SHALL hold, except in INIT where it SHALL load 0.
REQ-020 push SHALL be registered: on the clock edge after a cycle with pop=1, push[grant_idx_prev]=1; all other bits 0. This matches the 1-cycle read-data latency of the source FIFO.
REQ-021 At most one push bit SHALL be 1 in any cycle; push SHALL be all-zero in the cycle after pop=0.
REQ-022 Back-to-back pops SHALL produce back-to-back single-bit pushes. Full throughput is 1 word/cycle.
REQ-023 almost_full asserting in the cycle a push lands SHALL NOT cancel that push; the almost_full threshold accounts for one in-flight word.
REQ-024 Entering INIT mid-operation SHALL force pop=0 the same cycle; a push already registered from the previous cycle SHALL still complete.
REQ-025 All almost_full bits set SHALL give pop=0 with rr_ptr held, in both modes.

Reset
REQ-026 While reset_L=0: rr_ptr=0, push=0, stall_cnt=0; pop=0 is not forced by reset alone, because it is combinational from the inputs.
REQ-027 Reset assertion SHALL clear all flops immediately, without waiting for clk; deassertion is sampled at the next rising clk edge.

Configuration
REQ-028 Macro ARB_STALL_CNT_EN defined: stall_cnt increments on each cycle with state!=INIT_CODE, empty=0, and pop=0. It saturates at 16'hFFFF and clears to 0 in INIT.
REQ-029 Macro ARB_STALL_CNT_EN undefined: stall_cnt port and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 N_CH=4, SKIP_FULL=1, empty=0, almost_full=0, leave INIT: pops every cycle; push sequence from the following cycle is 0001, 0010, 0100, 1000, 0001.
REQ-031 N_CH=4, SKIP_FULL=1, almost_full=4'b0010, rr_ptr=1: grant_idx=2; next rr_ptr=3; push=0100 one cycle later.
REQ-032 Same setup with SKIP_FULL=0: pop=0 and rr_ptr stays 1 until almost_full[1] clears, then grant_idx=1.
REQ-033 N_CH=3, continuous traffic: grant_idx sequence is 0,1,2,0,1; rr_ptr never equals 3.
REQ-034 Streaming, then state=INIT_CODE for 2 cycles: pop=0 immediately; one trailing push completes; rr_ptr=0 after INIT; first grant after INIT is 0.
REQ-035 With ARB_STALL_CNT_EN, almost_full=all-ones, empty=0 for 70000 cycles: stall_cnt saturates at 16'hFFFF. Asserting reset_L=0 mid-clock clears it asynchronously.
